soft_rst_ctrl: RTL and testbench
================================

Name: soft_rst_ctrl

Overview:
- Generates the registered, glitch-free `software_rst` level that feeds the reset synchroniser stage.
- Accepts a single-cycle software reset request from the register interface and checks it against a magic key.
- Stretches an accepted request into a fixed-length reset pulse, then enforces a holdoff window in which new requests are refused.
- Reports busy, dropped-request and reset-count status back to the register file.

Parameters:
- PULSE_CYCLES, 16, length of the `software_rst` assertion in clk cycles; legal range ≥1.
- HOLDOFF_CYCLES, 32, cycles after deassertion during which requests are refused; legal range ≥0.
- KEY_W, 16, width of the request key.
- RST_KEY, 16'hA5C3, value `sw_rst_key` must equal for a request to be accepted.
- WDT_CYCLES, 1000000, watchdog timeout in clk cycles; used only with the optional feature.

Ports:
- clk  input  1  single clock domain.
- hardware_rst_n  input  1  asynchronous, active-low reset.
- sw_rst_req  input  1  single-cycle request strobe from the register write decode.
- sw_rst_key  input  KEY_W  key data qualified by `sw_rst_req`.
- wdt_kick  input  1  watchdog service strobe; ignored unless SOFT_RST_WDT_EN is defined.
- software_rst  output  1  registered reset level to the downstream synchroniser; active high.
- busy  output  1  high during the ASSERT and HOLDOFF states.
- req_dropped  output  1  one-cycle pulse: a request arrived while busy.
- key_err  output  1  one-cycle pulse: a request arrived in IDLE with the wrong key.
- rst_count  output  8  count of accepted resets; saturates at 255.
- wdt_expired  output  1  sticky watchdog-fired flag; tied to 0 when the feature is out.

Behaviour:
- Reset values (hardware_rst_n low, asynchronous): all outputs 0, state IDLE, all counters 0.
- Every output is driven directly from a flop. There is no combinational path from any input to any output.
- FSM states: IDLE, ASSERT, HOLDOFF.
- IDLE, with `sw_rst_req`=1 and `sw_rst_key`==RST_KEY:
  - Next cycle: state ASSERT, `software_rst`=1, `busy`=1.
  - Down-counter loaded with PULSE_CYCLES-1.
  - `rst_count` increments, saturating at 255.
  - Latency from request to reset assertion is 1 cycle.
- IDLE, with `sw_rst_req`=1 and a wrong key: `key_err`=1 on the next cycle, no state change.
- ASSERT:
  - Counter decrements each cycle.
  - At counter 0, the next state is HOLDOFF and `software_rst` goes to 0.
  - If HOLDOFF_CYCLES=0, the next state is IDLE instead.
  - Result: `software_rst` is high for exactly PULSE_CYCLES cycles.
- HOLDOFF:
  - Counter loaded with HOLDOFF_CYCLES-1 on entry.
  - At counter 0, the next state is IDLE and `busy` drops in the same cycle IDLE is entered.
- `sw_rst_req` in ASSERT or HOLDOFF:
  - Ignored.
  - `req_dropped`=1 for 1 cycle, whatever the key value.
  - `key_err` is not raised.
- A request accepted on the first IDLE cycle after HOLDOFF is legal.
- Counter width is $clog2(max(PULSE_CYCLES, HOLDOFF_CYCLES, 2)).
- `rst_count` has no clear other than `hardware_rst_n`.
- `hardware_rst_n` asserted mid-pulse: `software_rst` drops immediately (asynchronous). The block restarts in IDLE with no pending request.

Optional Feature:
- Macro: SOFT_RST_WDT_EN.
- Defined:
  - A 32-bit watchdog counter counts up in IDLE.
  - `wdt_kick`=1 clears the counter.
  - When the counter reaches WDT_CYCLES-1 in IDLE, an internal request is forced with key checking bypassed. This follows the same ASSERT/HOLDOFF path and the same 1-cycle latency, and increments `rst_count`.
  - `wdt_expired` is set and held until `hardware_rst_n`.
  - The watchdog counter is held at 0 while `busy`.
  - If the watchdog fires in the same cycle as a valid software request, only one reset results.
- Not defined: no watchdog logic is built, `wdt_expired`=0, and `wdt_kick` is unused.

Decomposition:
- Shared package `rst_pkg`:
  - FSM state enum (IDLE/ASSERT/HOLDOFF).
  - Default RST_KEY constant.
  - RST_COUNT_W=8.
- One natural sub-module: `rst_pulse_timer`, a loadable down-counter with a zero flag, instantiated once and reused for both ASSERT and HOLDOFF.

Test Plan (defaults unless noted):
- Request with key 16'hA5C3 at cycle 10 → `software_rst` high cycles 11–26 (16 cycles), `busy` high cycles 11–58, `rst_count`=1.
- Request with key 16'h0000 in IDLE → `key_err` pulses 1 cycle later; `software_rst` stays 0; `rst_count` unchanged.
- Valid request, then a second valid request 5 cycles and 30 cycles later → two `req_dropped` pulses, `rst_count`=1. A third request on the first IDLE cycle is accepted → `rst_count`=2.
- HOLDOFF_CYCLES=0, PULSE_CYCLES=1 → exactly 1-cycle `software_rst` pulse; back-to-back valid requests every 2 cycles are all accepted.
- `hardware_rst_n` low at cycle 5 of a pulse → `software_rst`, `busy` and `rst_count` at 0 immediately; after release, a valid request produces a full 16-cycle pulse.
- SOFT_RST_WDT_EN, WDT_CYCLES=100:
  - No kick → reset pulse starts 100 cycles after entering IDLE, and `wdt_expired` is sticky.
  - Kick every 50 cycles → no reset.

Source files
------------

// File: rtl/rst_pkg.sv
// ============================================================================
// Module      : rst_pkg
// Description : Shared FSM state type and constants for the soft reset block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_HOLDOFF = 2'd2
   } rst_state_e;

   localparam logic [15:0] RST_KEY_DEFAULT = 16'hA5C3;
   localparam int          RST_COUNT_W     = 8;

   // Timer width must cover both the pulse and holdoff reload values.
   function automatic int cnt_width(input int pulse, input int hold);
      int m;
      m = (pulse > hold) ? pulse : hold;
      if (m < 2) m = 2;
      return $clog2(m);
   endfunction

endpackage

`default_nettype wire

// File: rtl/rst_pulse_timer.sv
// ============================================================================
// Module      : rst_pulse_timer
// Description : Loadable down-counter with a zero flag; stops at zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_pulse_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/soft_rst_ctrl.sv
// ============================================================================
// Module      : soft_rst_ctrl
// Description : Key-checked software reset pulse generator with holdoff.
//               Optional watchdog enabled by defining SOFT_RST_WDT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module soft_rst_ctrl
   import rst_pkg::*;
#(
   parameter int               PULSE_CYCLES   = 16,
   parameter int               HOLDOFF_CYCLES = 32,
   parameter int               KEY_W          = 16,
   parameter logic [KEY_W-1:0] RST_KEY        = KEY_W'(RST_KEY_DEFAULT),
   parameter int               WDT_CYCLES     = 1000000
) (
   input  logic                   clk,
   input  logic                   hardware_rst_n,
   input  logic                   sw_rst_req,
   input  logic [KEY_W-1:0]       sw_rst_key,
   input  logic                   wdt_kick,
   output logic                   software_rst,
   output logic                   busy,
   output logic                   req_dropped,
   output logic                   key_err,
   output logic [RST_COUNT_W-1:0] rst_count,
   output logic                   wdt_expired
);

   localparam int                 C_CNT_W      = cnt_width(PULSE_CYCLES, HOLDOFF_CYCLES);
   localparam logic [C_CNT_W-1:0] C_PULSE_LOAD = C_CNT_W'(PULSE_CYCLES - 1);
   localparam logic [C_CNT_W-1:0] C_HOLD_LOAD  =
      C_CNT_W'((HOLDOFF_CYCLES > 0) ? (HOLDOFF_CYCLES - 1) : 0);

   rst_state_e             r_state;
   rst_state_e             w_state_nxt;
   logic                   w_tmr_load;
   logic                   w_tmr_dec;
   logic                   w_tmr_zero;
   logic [C_CNT_W-1:0]     w_tmr_val;
   logic                   w_idle;
   logic                   w_key_ok;
   logic                   w_force;
   logic                   w_accept;
   logic                   r_software_rst;
   logic                   r_busy;
   logic                   r_req_dropped;
   logic                   r_key_err;
   logic [RST_COUNT_W-1:0] r_rst_count;
   logic                   r_wdt_expired;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_key_ok = (sw_rst_key == RST_KEY);
   // A watchdog-forced request and a software request in the same cycle merge into one.
   assign w_accept = w_idle && ((sw_rst_req && w_key_ok) || w_force);

`ifdef SOFT_RST_WDT_EN
   logic [31:0] r_wdt_cnt;

   assign w_force = w_idle && !wdt_kick && (r_wdt_cnt == 32'(WDT_CYCLES - 1));

   always_ff @(posedge clk or negedge hardware_rst_n) begin
      if (!hardware_rst_n) begin
         r_wdt_cnt     <= '0;
         r_wdt_expired <= 1'b0;
      end else begin
         if (!w_idle || wdt_kick || w_force) begin
            r_wdt_cnt <= '0;
         end else begin
            r_wdt_cnt <= r_wdt_cnt + 32'd1;
         end
         if (w_force) begin
            r_wdt_expired <= 1'b1;
         end
      end
   end
`else
   logic w_unused;

   assign w_unused      = ^{wdt_kick, 32'(WDT_CYCLES)};
   assign w_force       = 1'b0;
   assign r_wdt_expired = 1'b0;
`endif

   rst_pulse_timer #(
      .CNT_W (C_CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (hardware_rst_n),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_dec      (w_tmr_dec),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk or negedge hardware_rst_n) begin
      if (!hardware_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_tmr_load  = 1'b0;
      w_tmr_val   = C_PULSE_LOAD;
      w_tmr_dec   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_ASSERT;
               w_tmr_load  = 1'b1;
            end
         end
         ST_ASSERT: begin
            if (!w_tmr_zero) begin
               w_tmr_dec = 1'b1;
            end else if (HOLDOFF_CYCLES == 0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_HOLDOFF;
               w_tmr_load  = 1'b1;
               w_tmr_val   = C_HOLD_LOAD;
            end
         end
         ST_HOLDOFF: begin
            if (!w_tmr_zero) begin
               w_tmr_dec = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they align with the state.
   always_ff @(posedge clk or negedge hardware_rst_n) begin
      if (!hardware_rst_n) begin
         r_software_rst <= 1'b0;
         r_busy         <= 1'b0;
         r_req_dropped  <= 1'b0;
         r_key_err      <= 1'b0;
         r_rst_count    <= '0;
      end else begin
         r_software_rst <= (w_state_nxt == ST_ASSERT);
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_req_dropped  <= sw_rst_req && !w_idle;
         r_key_err      <= sw_rst_req && w_idle && !w_key_ok;
         if (w_accept && (r_rst_count != '1)) begin
            r_rst_count <= r_rst_count + RST_COUNT_W'(1);
         end
      end
   end

   assign software_rst = r_software_rst;
   assign busy         = r_busy;
   assign req_dropped  = r_req_dropped;
   assign key_err      = r_key_err;
   assign rst_count    = r_rst_count;
   assign wdt_expired  = r_wdt_expired;

endmodule

`default_nettype wire

// File: tb/tb_soft_rst_ctrl.sv
// ============================================================================
// Module      : tb_soft_rst_ctrl
// Description : Self-checking bench for soft_rst_ctrl (SOFT_RST_WDT_EN optional).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soft_rst_ctrl;

   localparam int          P   = 16;
   localparam int          H   = 32;
   localparam logic [15:0] KEY = 16'hA5C3;

   logic        clk;
   logic        rst_n;
   logic        req_a, req_b, kick;
   logic [15:0] key_a, key_b;
   logic        soft_a, busy_a, drop_a, kerr_a, wdt_a;
   logic        soft_b, busy_b, drop_b, kerr_b, wdt_b;
   logic        soft_w, busy_w, drop_w, kerr_w, wdt_w;
   logic [7:0]  cnt_a, cnt_b, cnt_w;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state: remaining busy / reset cycles
   int m_busy, m_rst, m_cnt;
   bit m_kerr, m_drop;

   typedef struct {
      logic        req;
      logic [15:0] key;
      logic        e_rst;
      logic        e_busy;
      logic        e_kerr;
      logic        e_drop;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t vecs[8];

   soft_rst_ctrl dut_a (
      .clk (clk), .hardware_rst_n (rst_n), .sw_rst_req (req_a), .sw_rst_key (key_a),
      .wdt_kick (1'b0), .software_rst (soft_a), .busy (busy_a), .req_dropped (drop_a),
      .key_err (kerr_a), .rst_count (cnt_a), .wdt_expired (wdt_a)
   );

   soft_rst_ctrl #(.PULSE_CYCLES (1), .HOLDOFF_CYCLES (0)) dut_b (
      .clk (clk), .hardware_rst_n (rst_n), .sw_rst_req (req_b), .sw_rst_key (key_b),
      .wdt_kick (1'b0), .software_rst (soft_b), .busy (busy_b), .req_dropped (drop_b),
      .key_err (kerr_b), .rst_count (cnt_b), .wdt_expired (wdt_b)
   );

   soft_rst_ctrl #(.WDT_CYCLES (100)) dut_w (
      .clk (clk), .hardware_rst_n (rst_n), .sw_rst_req (1'b0), .sw_rst_key (16'h0000),
      .wdt_kick (kick), .software_rst (soft_w), .busy (busy_w), .req_dropped (drop_w),
      .key_err (kerr_w), .rst_count (cnt_w), .wdt_expired (wdt_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req_a = 1'b0; req_b = 1'b0; kick = 1'b0;
      key_a = 16'h0; key_b = 16'h0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      m_busy = 0; m_rst = 0; m_cnt = 0; m_kerr = 0; m_drop = 0;
   endtask

   // One clock of the specified behaviour, abstracted as remaining-cycle budgets.
   task automatic model_step(input bit req, input logic [15:0] key);
      m_kerr = 0;
      m_drop = 0;
      if (m_busy > 0) begin
         m_drop = req;
         m_busy--;
         if (m_rst > 0) m_rst--;
      end else if (req) begin
         if (key == KEY) begin
            m_busy = P + H;
            m_rst  = P;
            if (m_cnt < 255) m_cnt++;
         end else begin
            m_kerr = 1;
         end
      end
   endtask

   initial begin
      int n_rst, n_busy, n_drop, i;
      bit fired;

      vecs[0] = '{1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
      vecs[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2] = '{1'b1, KEY,      1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[3] = '{1'b1, KEY,      1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[4] = '{1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
      vecs[6] = '{1'b1, KEY,      1'b1, 1'b1, 1'b0, 1'b1, 8'd1};
      vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};

      // reset state
      do_reset();
      check("rst_soft", soft_a, 0);
      check("rst_busy", busy_a, 0);
      check("rst_drop", drop_a, 0);
      check("rst_kerr", kerr_a, 0);
      check("rst_cnt",  cnt_a,  0);
      check("rst_wdt",  wdt_a,  0);

      // table-driven vectors
      for (int v = 0; v < 8; v++) begin
         req_a = vecs[v].req;
         key_a = vecs[v].key;
         tick();
         check($sformatf("vec%0d_soft", v), soft_a, vecs[v].e_rst);
         check($sformatf("vec%0d_busy", v), busy_a, vecs[v].e_busy);
         check($sformatf("vec%0d_kerr", v), kerr_a, vecs[v].e_kerr);
         check($sformatf("vec%0d_drop", v), drop_a, vecs[v].e_drop);
         check($sformatf("vec%0d_cnt",  v), cnt_a,  vecs[v].e_cnt);
      end
      req_a = 1'b0;

      // full pulse/holdoff timing with requests dropped at pulse cycles 5 and 30
      do_reset();
      repeat (10) tick();
      req_a = 1'b1; key_a = KEY;
      tick();
      n_rst = 0; n_busy = 0; n_drop = 0; i = 0;
      while (busy_a && i < 200) begin
         n_rst  += int'(soft_a);
         n_busy++;
         n_drop += int'(drop_a);
         req_a = (i == 4 || i == 29);
         tick();
         i++;
      end
      check("busy_bounded", (i < 200), 1);
      check("pulse_len", n_rst, P);
      check("busy_len", n_busy, P + H);
      check("drops", n_drop, 2);
      check("cnt_after_drops", cnt_a, 1);
      req_a = 1'b1; key_a = KEY;
      tick();
      req_a = 1'b0;
      check("first_idle_accept", soft_a, 1);
      check("cnt_second", cnt_a, 2);

      // asynchronous hardware reset in the middle of a pulse
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_soft", soft_a, 0);
      check("async_busy", busy_a, 0);
      check("async_cnt", cnt_a, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      req_a = 1'b1; key_a = KEY;
      tick();
      req_a = 1'b0;
      n_rst = 0; i = 0;
      while (soft_a && i < 100) begin
         n_rst++;
         tick();
         i++;
      end
      check("pulse_after_hw_rst", n_rst, P);

      // PULSE_CYCLES=1, HOLDOFF_CYCLES=0: a request every second cycle
      do_reset();
      for (int k = 0; k < 4; k++) begin
         req_b = 1'b1; key_b = KEY;
         tick();
         check($sformatf("b%0d_soft_hi", k), soft_b, 1);
         check($sformatf("b%0d_busy_hi", k), busy_b, 1);
         req_b = 1'b0;
         tick();
         check($sformatf("b%0d_soft_lo", k), soft_b, 0);
         check($sformatf("b%0d_busy_lo", k), busy_b, 0);
      end
      check("b_cnt4", cnt_b, 4);
      for (int k = 0; k < 260; k++) begin
         req_b = 1'b1; key_b = KEY;
         tick();
         req_b = 1'b0;
         tick();
      end
      check("b_cnt_sat", cnt_b, 255);

      // randomized traffic against the reference model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         req_a = ($urandom_range(0, 5) == 0);
         key_a = ($urandom_range(0, 1) == 0) ? KEY : 16'($urandom);
         model_step(req_a, key_a);
         tick();
         check("rnd_soft", soft_a, (m_rst > 0));
         check("rnd_busy", busy_a, (m_busy > 0));
         check("rnd_kerr", kerr_a, m_kerr);
         check("rnd_drop", drop_a, m_drop);
         check("rnd_cnt",  cnt_a,  m_cnt);
      end
      req_a = 1'b0;
      check("rnd_wdt", wdt_a, 0);

`ifdef SOFT_RST_WDT_EN
      // watchdog: no kick fires after WDT_CYCLES idle cycles
      do_reset();
      i = 0;
      while (!soft_w && i < 300) begin
         tick();
         i++;
      end
      check("wdt_latency", i, 100);
      check("wdt_flag", wdt_w, 1);
      check("wdt_cnt", cnt_w, 1);
      repeat (60) tick();
      check("wdt_sticky", wdt_w, 1);

      // periodic kicks keep it quiet
      do_reset();
      fired = 0;
      for (int k = 0; k < 300; k++) begin
         kick = (k % 50 == 0);
         tick();
         fired |= soft_w;
      end
      kick = 1'b0;
      check("wdt_kick_no_rst", fired, 0);
      check("wdt_kick_flag", wdt_w, 0);
`else
      do_reset();
      fired = 0;
      for (int k = 0; k < 150; k++) begin
         tick();
         fired |= soft_w;
      end
      check("nowdt_no_rst", fired, 0);
      check("nowdt_flag", wdt_w, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
